// File: rtl/mips_mem_pkg.sv
// Shared store-size encodings and store FSM state type.
// Used by store_narrow and its lane merge sub-module.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_e;

  // Both 2'b10 and 2'b11 encode a full-word store.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/store_narrow_lane_merge.sv
// lane_merge: combinational little-endian byte/half/word merge of store data
// into a previously read memory word.
module lane_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] wdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_take;
      logic [7:0] w_src;

      // A half store covers the byte pair selected by lane[1].
      assign w_take = is_word(size)
                   || ((size == SZ_HALF) && (lane[1] == LANE[1]))
                   || ((size == SZ_BYTE) && (lane == LANE));
      assign w_src  = is_word(size)     ? data[gi*8 +: 8]
                    : (size == SZ_HALF) ? data[(gi%2)*8 +: 8]
                    :                     data[7:0];
      assign wdata[gi*8 +: 8] = w_take ? w_src : rdata[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/store_narrow.sv
// store_narrow: SB/SH/SW store engine; narrow stores do read-merge-write.
// Optional alignment check enabled by defining STORE_NARROW_CHECK_EN.
module store_narrow
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err_misaligned
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata;
  logic [31:0]       w_merged;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_take;

`ifdef STORE_NARROW_CHECK_EN
  assign w_misaligned = ((req_size == SZ_HALF) && req_addr[0])
                     || (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Gating with rst_n keeps the handshake and error pulse silent during reset.
  assign req_ready      = (r_state == S_IDLE) && rst_n;
  assign w_accept       = req_valid && req_ready;
  assign w_take         = w_accept && !w_misaligned;
  assign err_misaligned = w_accept && w_misaligned;

  lane_merge u_merge (
    .rdata (mem_rdata),
    .data  (r_data),
    .size  (r_size),
    .lane  (r_addr[1:0]),
    .wdata (w_merged)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_take) w_state_next = is_word(req_size) ? S_WR : S_RD;
      S_RD:   w_state_next = S_WAIT;
      S_WAIT: if (mem_rvalid) w_state_next = S_WR;
      S_WR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_addr  <= req_addr;
        r_data  <= req_data;
        r_size  <= req_size;
        r_wdata <= is_word(req_size) ? req_data : 32'h0;
      end else if ((r_state == S_WAIT) && mem_rvalid) begin
        r_wdata <= w_merged;
      end
    end
  end

  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_rd_en = (r_state == S_RD);
  assign mem_wr_en = (r_state == S_WR);
  assign done      = (r_state == S_WR);
  assign mem_wdata = (r_state == S_WR) ? r_wdata : 32'h0;

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow (SB/SH/SW, misaligned,
// reset mid-transaction, spurious rvalid, back-to-back requests).
module tb_store_narrow;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_narrow #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_size       (req_size),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .mem_wr_en      (mem_wr_en),
    .mem_wdata      (mem_wdata),
    .done           (done),
    .err_misaligned (err_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},   mem_rd_en, 0);
    chk({tag, "_wr"},   mem_wr_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"},  err_misaligned, 0);
    chk({tag, "_wd"},   mem_wdata, 0);
  endtask

  task automatic narrow(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic [31:0] rdata, input int delay,
                        input logic [31:0] exp);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
    #1;
    chk({tag, "_acc_ready"}, req_ready, 1);
    chk({tag, "_acc_rd"}, mem_rd_en, 0);
    tick();
    req_valid = 1'b0; req_data = 32'hFFFFFFFF; req_addr = 32'hFFFFFFFF;
    #1;
    chk({tag, "_rd_en"}, mem_rd_en, 1);
    chk({tag, "_rd_addr"}, mem_addr, waddr);
    chk({tag, "_rd_ready"}, req_ready, 0);
    tick();
    for (int i = 0; i < delay; i++) begin
      #1;
      chk({tag, "_wait_rd"}, mem_rd_en, 0);
      chk({tag, "_wait_wr"}, mem_wr_en, 0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    #1;
    chk({tag, "_wait_wd"}, mem_wdata, 0);
    chk({tag, "_wait_rd1"}, mem_rd_en, 0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0BADF00D;
    #1;
    chk({tag, "_wr_en"}, mem_wr_en, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wdata"}, mem_wdata, exp);
    chk({tag, "_wr_addr"}, mem_addr, waddr);
    tick();
    #1;
    chk({tag, "_idle_wr"}, mem_wr_en, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
    $display("txn %s addr=0x%08h size=%0d wdata=0x%08h", tag, addr, size, exp);
  endtask

  task automatic word(input string tag, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = SZ_WORD;
    #1;
    chk({tag, "_acc_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0; req_data = 32'h0;
    #1;
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wdata"}, mem_wdata, data);
    chk({tag, "_wr_addr"}, mem_addr, {addr[31:2], 2'b00});
    tick();
    #1;
    chk({tag, "_idle_wr"}, mem_wr_en, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
    $display("txn %s addr=0x%08h size=2 wdata=0x%08h", tag, addr, data);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    tick();

    narrow("sb", 32'h1003, 32'h000000AB, SZ_BYTE, 32'h11223344, 0, 32'hAB223344);
    narrow("sh", 32'h2002, 32'hFFFF5678, SZ_HALF, 32'hDEADBEEF, 3, 32'h5678BEEF);
    word("sw", 32'h3000, 32'hCAFEF00D);
    narrow("sb_l1", 32'h1001, 32'h00000055, SZ_BYTE, 32'h11223344, 1, 32'h11225544);

`ifdef STORE_NARROW_CHECK_EN
    req_valid = 1'b1; req_addr = 32'h4001; req_data = 32'h00001234; req_size = SZ_HALF;
    #1;
    chk("mis_err", err_misaligned, 1);
    chk("mis_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    chk_quiet("mis_after");
    chk("mis_after_ready", req_ready, 1);
    tick();
    #1;
    chk_quiet("mis_after2");
    $display("txn sh_mis addr=0x00004001 rejected");
`else
    narrow("sh_mis", 32'h4001, 32'h00001234, SZ_HALF, 32'hAAAAAAAA, 0, 32'hAAAA1234);
`endif

    // Reset while waiting for read data.
    req_valid = 1'b1; req_addr = 32'h1002; req_data = 32'h00000099; req_size = SZ_BYTE;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    chk("rw_in_wait_rd", mem_rd_en, 0);
    rst_n = 1'b0;
    #1;
    chk_quiet("rw_rst");
    chk("rw_rst_addr", mem_addr, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    #1;
    chk_quiet("rw_rst2");
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk_quiet("rw_post");
    chk("rw_post_ready", req_ready, 1);
    $display("txn reset_in_wait no write");
    narrow("sb_post", 32'h5001, 32'h00000077, SZ_BYTE, 32'h00000000, 2, 32'h00007700);

    // Spurious rvalid in IDLE, then back-to-back word requests.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk_quiet("spur");
    chk("spur_ready", req_ready, 1);
    tick();
    req_valid = 1'b1; req_addr = 32'h6000; req_data = 32'h11111111; req_size = SZ_WORD;
    #1;
    chk("b2b_acc1", req_ready, 1);
    tick();
    req_addr = 32'h7004; req_data = 32'h22222222; req_size = SZ_WORD;
    #1;
    chk("b2b_busy_ready", req_ready, 0);
    chk("b2b_wr1", mem_wr_en, 1);
    chk("b2b_wd1", mem_wdata, 32'h11111111);
    chk("b2b_a1", mem_addr, 32'h6000);
    tick();
    #1;
    chk("b2b_acc2", req_ready, 1);
    chk("b2b_idle_wr", mem_wr_en, 0);
    chk("b2b_idle_rd", mem_rd_en, 0);
    tick();
    req_valid = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("b2b_wr2", mem_wr_en, 1);
    chk("b2b_wd2", mem_wdata, 32'h22222222);
    chk("b2b_a2", mem_addr, 32'h7004);
    chk("b2b_rd2", mem_rd_en, 0);
    tick();
    #1;
    chk_quiet("b2b_end");
    $display("txn back_to_back 0x6000 0x7004");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
